if_id_queue: RTL

Parametrised successor to the single-entry IF/ID pipeline register. It adds a DEPTH-entry instruction queue between fetch and decode, so the IF stage keeps fetching while ID is stalled. A registered head is presented to ID with a valid flag. The block keeps the six-bit stall vector and the jump/interrupt flush semantics, and adds an empty-queue bypass so the common-case latency stays at one cycle.

---
 rtl/if_id_queue.sv | 127 ++++++++++++
 1 files changed

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: a DEPTH-entry circular buffer that feeds a registered head to decode.
// Defining IF_ID_QUEUE_BYPASS_EN lets an empty queue forward the fetched instruction straight to the output.
module if_id_queue #(
  parameter int unsigned         ADDR_WIDTH = 32,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [5:0]                   stall_i,
  input  logic                         flush_jump_i,
  input  logic                         flush_int_i,
  input  logic                         inst_valid_i,
  input  logic [ADDR_WIDTH-1:0]        inst_addr_i,
  input  logic [DATA_WIDTH-1:0]        inst_i,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         inst_valid_o,
  output logic [ADDR_WIDTH-1:0]        inst_addr_o,
  output logic [DATA_WIDTH-1:0]        inst_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [DATA_WIDTH-1:0] out_inst_q, out_inst_d;

  logic flush;
  logic push;
  logic pop;

  assign full_o       = (count_q == FULL_CNT);
  assign count_o      = count_q;
  assign inst_valid_o = out_valid_q;
  assign inst_addr_o  = out_addr_q;
  assign inst_o       = out_inst_q;

  always_comb begin
    flush       = flush_jump_i | flush_int_i;
    push        = inst_valid_i & ~full_o & ~flush;
    pop         = 1'b0;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_inst_d  = out_inst_q;

    if (flush) begin
      out_valid_d = 1'b0;
      out_addr_d  = '0;
      out_inst_d  = NOP_INST;
    end else if (stall_i[2]) begin
      // ID stalled: head is held, queue keeps filling
    end else if (stall_i[1]) begin
      out_valid_d = 1'b0;
      out_addr_d  = '0;
      out_inst_d  = NOP_INST;
    end else if (count_q != '0) begin
      pop         = 1'b1;
      out_valid_d = 1'b1;
      out_addr_d  = addr_mem_q[rd_ptr_q];
      out_inst_d  = data_mem_q[rd_ptr_q];
    end else begin
`ifdef IF_ID_QUEUE_BYPASS_EN
      if (inst_valid_i) begin
        push        = 1'b0;
        out_valid_d = 1'b1;
        out_addr_d  = inst_addr_i;
        out_inst_d  = inst_i;
      end else begin
        out_valid_d = 1'b0;
        out_addr_d  = '0;
        out_inst_d  = NOP_INST;
      end
`else
      out_valid_d = 1'b0;
      out_addr_d  = '0;
      out_inst_d  = NOP_INST;
`endif
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_inst_q  <= NOP_INST;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_inst_q  <= out_inst_d;
    end
  end

  // Storage carries no reset; occupancy and pointers alone define what is live.
  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      addr_mem_q[wr_ptr_q] <= inst_addr_i;
      data_mem_q[wr_ptr_q] <= inst_i;
    end
  end

endmodule
